// File: rtl/spi_burst_seq.sv
`default_nettype none
// ============================================================================
// Module  : spi_burst_seq
// Purpose : Runs multi-byte full-duplex SPI bursts on the SPI register port
//           from a local byte buffer. RX bytes overwrite their TX slots.
//           Optional macro SPI_SEQ_HOLD_CS_EN adds hold_cs (skip deselect).
// Revision: 1.0 - initial release
// ============================================================================
module spi_burst_seq #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [2:0]    cs_sel,
  input  logic [2:0]    clk_div,
`ifdef SPI_SEQ_HOLD_CS_EN
  input  logic          hold_cs,
`endif
  output logic          busy,
  output logic          done,
  output logic          error,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_waddr,
  input  logic [7:0]    buf_wdata,
  input  logic [AW-1:0] buf_raddr,
  output logic [7:0]    buf_rdata,
  output logic [7:0]    m_addr,
  output logic [15:0]   m_data_write,
  input  logic [15:0]   m_data_read,
  output logic          m_uds,
  output logic          m_lds,
  output logic          m_rw,
  input  logic          m_ack
);

  localparam logic [AW:0] c_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_ONE     = (AW+1)'(1);
  localparam logic [7:0]  c_TIMEOUT = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_TX, S_POLL, S_RX, S_DESEL, S_DONE, S_WAIT
  } state_t;

  state_t        r_state, r_pend;
  logic [AW:0]   r_len;
  logic [AW-1:0] r_idx;
  logic [2:0]    r_cs, r_div;
  logic [7:0]    r_cnt;
  logic          r_hold, r_busy, r_done, r_error;
  logic          r_uds, r_lds, r_rw;
  logic [15:0]   r_wdata;
  logic [7:0]    r_rdata;
  logic [7:0]    r_mem [DEPTH];

  logic [AW:0]   w_idx_next;
  logic          w_last, w_rx_we, w_hold_in, w_unused_bits;

  assign w_idx_next    = {1'b0, r_idx} + c_ONE;
  assign w_last        = (w_idx_next == r_len);
  assign w_rx_we       = reset_n && (r_state == S_WAIT) && (r_pend == S_RX) && m_ack;
  assign w_unused_bits = ^m_data_read[7:1];
`ifdef SPI_SEQ_HOLD_CS_EN
  assign w_hold_in = hold_cs;
`else
  assign w_hold_in = 1'b0;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign buf_rdata    = r_rdata;
  assign m_addr       = 8'h00;
  assign m_data_write = r_wdata;
  assign m_uds        = r_uds;
  assign m_lds        = r_lds;
  assign m_rw         = r_rw;

  // Buffer storage is deliberately not reset; the client owns it while idle
  always_ff @(posedge clk) begin
    if (w_rx_we)
      r_mem[r_idx] <= m_data_read[15:8];
    else if (reset_n && buf_we && !r_busy)
      r_mem[buf_waddr] <= buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= r_mem[buf_raddr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pend  <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_cs    <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_uds   <= 1'b0;
      r_lds   <= 1'b0;
      r_rw    <= 1'b1;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_uds  <= 1'b0;
      r_lds  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_len   <= (len > c_DEPTH) ? c_DEPTH : len;
          r_cs    <= cs_sel;
          r_div   <= clk_div;
          r_hold  <= w_hold_in;
          r_idx   <= '0;
          r_error <= 1'b0;
          if (len == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_CFG;
          end
        end
        S_CFG: begin
          r_lds   <= 1'b1;
          r_rw    <= 1'b0;
          r_wdata <= {9'b0, r_cs, r_div, 1'b0};
          r_pend  <= S_CFG;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_TX: begin
          r_uds   <= 1'b1;
          r_rw    <= 1'b0;
          r_wdata <= {r_mem[r_idx], 8'h00};
          r_pend  <= S_TX;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_POLL: begin
          r_lds   <= 1'b1;
          r_rw    <= 1'b1;
          r_pend  <= S_POLL;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_RX: begin
          r_uds   <= 1'b1;
          r_rw    <= 1'b1;
          r_pend  <= S_RX;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_DESEL: begin
          r_lds   <= 1'b1;
          r_rw    <= 1'b0;
          r_wdata <= {9'b0, 3'b000, r_div, 1'b0};
          r_pend  <= S_DESEL;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (m_ack) begin
            case (r_pend)
              S_CFG:  r_state <= S_TX;
              S_TX:   r_state <= S_POLL;
              S_POLL: r_state <= m_data_read[0] ? S_POLL : S_RX;
              S_RX: begin
                r_idx <= w_idx_next[AW-1:0];
                if (!w_last) begin
                  r_state <= S_TX;
                end else if (r_hold) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_state <= S_DESEL;
                end
              end
              S_DESEL: begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
              default: r_state <= S_IDLE;
            endcase
          end else if (r_cnt == c_TIMEOUT) begin
            // Abandon the burst; chip select is intentionally left as-is
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_rw    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
